// File: rtl/bus_rx_node.sv
// Single-wire node bus receiver: deserializes frames, filters on destination address and checks the CRC-4.
// Optional macro BUS_RX_BROADCAST_EN makes dest 4'hF match every node.
module bus_rx_node #(
  parameter int          DATA_W   = 64,
  parameter logic [3:0]  CRC_POLY = 4'h3,
  parameter logic [3:0]  CRC_INIT = 4'h0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bus,
  input  logic [3:0]        addr,
  output logic [DATA_W-1:0] data,
  output logic [3:0]        src_addr,
  output logic [1:0]        mod,
  output logic              valid,
  output logic              crc_err,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_CRCF,
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [6:0]         r_cnt;
  logic [6:0]         w_cnt_nxt;
  logic [3:0]         r_crc;
  logic [3:0]         w_crc_nxt;
  logic [3:0]         w_crc_step;
  logic [8:0]         r_hdr;
  logic [3:0]         r_dest;
  logic [3:0]         r_src;
  logic [1:0]         r_mod;
  logic [DATA_W-1:0]  r_shift;
  logic [3:0]         r_crc_rx;
  logic               w_eval;
  logic               w_ferr;
  logic               w_match;
  logic               w_crc_ok;
  logic               w_set_valid;
  logic               w_set_crc_err;

  assign w_crc_step = {r_crc[2:0], 1'b0} ^ ((r_crc[3] ^ bus) ? CRC_POLY : 4'h0);
  assign w_crc_ok   = (r_crc == r_crc_rx);

`ifdef BUS_RX_BROADCAST_EN
  assign w_match = (r_dest == addr) || (r_dest == 4'hF);
`else
  assign w_match = (r_dest == addr);
`endif

  assign w_set_valid   = w_eval & w_match & w_crc_ok;
  assign w_set_crc_err = w_eval & w_match & ~w_crc_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 7'd0;
      r_crc   <= CRC_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_crc   <= w_crc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_crc_nxt   = r_crc;
    w_eval      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus) begin
          w_state_nxt = S_HDR;
          w_cnt_nxt   = 7'd10;
          w_crc_nxt   = CRC_INIT;
        end
      end
      S_HDR: begin
        w_crc_nxt = w_crc_step;
        w_cnt_nxt = r_cnt - 7'd1;
        if (r_cnt == 7'd1) begin
          // mod is the last two header bits: the previous bit and the one on the wire now
          w_state_nxt = S_PAY;
          w_cnt_nxt   = 7'd8 << {r_hdr[0], bus};
        end
      end
      S_PAY: begin
        w_crc_nxt = w_crc_step;
        w_cnt_nxt = r_cnt - 7'd1;
        if (r_cnt == 7'd1) begin
          w_state_nxt = S_CRCF;
          w_cnt_nxt   = 7'd4;
        end
      end
      S_CRCF: begin
        w_cnt_nxt = r_cnt - 7'd1;
        if (r_cnt == 7'd1) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (bus) begin
          w_state_nxt = S_IDLE;
          w_eval      = 1'b1;
        end else begin
          w_state_nxt = S_WAIT_HI;
          w_ferr      = 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (bus) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hdr    <= 9'd0;
      r_dest   <= 4'd0;
      r_src    <= 4'd0;
      r_mod    <= 2'd0;
      r_shift  <= '0;
      r_crc_rx <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus) begin
            r_shift <= '0;
          end
        end
        S_HDR: begin
          r_hdr <= {r_hdr[7:0], bus};
          if (r_cnt == 7'd1) begin
            {r_dest, r_src, r_mod} <= {r_hdr, bus};
          end
        end
        S_PAY: begin
          r_shift <= {r_shift[DATA_W-2:0], bus};
        end
        S_CRCF: begin
          r_crc_rx <= {r_crc_rx[2:0], bus};
        end
        default: begin
        end
      endcase
    end
  end

  // Result pulses are registered, so they appear in the cycle after the stop bit while IDLE looks for the next start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid     <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      data      <= '0;
      src_addr  <= 4'd0;
      mod       <= 2'd0;
    end else begin
      valid     <= w_set_valid;
      crc_err   <= w_set_crc_err;
      frame_err <= w_ferr;
      if (w_set_valid) begin
        data     <= r_shift;
        src_addr <= r_src;
        mod      <= r_mod;
      end
    end
  end

endmodule

// File: tb/tb_bus_rx_node.sv
// Directed bench for bus_rx_node: frames are driven on the falling edge, outputs sampled on the falling edge.
module tb_bus_rx_node;

  logic        clock;
  logic        reset_n;
  logic        bus;
  logic [3:0]  addr;
  logic [63:0] data;
  logic [3:0]  src_addr;
  logic [1:0]  mod;
  logic        valid;
  logic        crc_err;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_crc    = 0;
  int n_ferr   = 0;
  int b_valid, b_crc, b_ferr;
  logic s_valid, s_crc_err, s_frame_err;

  bus_rx_node dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .addr      (addr),
    .data      (data),
    .src_addr  (src_addr),
    .mod       (mod),
    .valid     (valid),
    .crc_err   (crc_err),
    .frame_err (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (valid)     n_valid++;
    if (crc_err)   n_crc++;
    if (frame_err) n_ferr++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] crc_of(input logic [3:0] d, input logic [3:0] s,
                                        input logic [1:0] m, input logic [63:0] p);
    logic [3:0] c;
    logic [9:0] h;
    int len;
    c   = 4'h0;
    h   = {d, s, m};
    len = 8 << m;
    for (int i = 9; i >= 0; i--) c = crc_step(c, h[i]);
    for (int i = len - 1; i >= 0; i--) c = crc_step(c, p[i]);
    return c;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic mark();
    b_valid = n_valid;
    b_crc   = n_crc;
    b_ferr  = n_ferr;
  endtask

  // Starts and ends on a falling edge; the bus is left at the stop level.
  task automatic send_frame(input logic [3:0] d, input logic [3:0] s, input logic [1:0] m,
                            input logic [63:0] p, input logic [3:0] c, input logic stp,
                            input int rst_at);
    int len;
    len = 8 << m;
    bus = 1'b0;
    @(negedge clock);
    for (int i = 3; i >= 0; i--) begin bus = d[i]; @(negedge clock); end
    for (int i = 3; i >= 0; i--) begin bus = s[i]; @(negedge clock); end
    for (int i = 1; i >= 0; i--) begin bus = m[i]; @(negedge clock); end
    for (int k = 0; k < len; k++) begin
      if (rst_at >= 0 && k == rst_at)     reset_n = 1'b0;
      if (rst_at >= 0 && k == rst_at + 2) reset_n = 1'b1;
      bus = p[len-1-k];
      @(negedge clock);
    end
    for (int i = 3; i >= 0; i--) begin bus = c[i]; @(negedge clock); end
    bus = stp;
    @(negedge clock);
    s_valid     = valid;
    s_crc_err   = crc_err;
    s_frame_err = frame_err;
  endtask

  initial begin
    bus     = 1'b1;
    addr    = 4'h1;
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    mark();
    idle(50);
    chk("rst_data", data, 64'h0);
    chk("rst_src", {60'h0, src_addr}, 64'h0);
    chk("rst_mod", {62'h0, mod}, 64'h0);
    chk("idle_pulses", n_valid + n_crc + n_ferr - b_valid - b_crc - b_ferr, 0);

    // Good 8-bit frame; hand-computed CRC 4'hB.
    mark();
    send_frame(4'h1, 4'h0, 2'd0, 64'h01, 4'hB, 1'b1, -1);
    chk("t2_valid", s_valid, 1);
    chk("t2_data", data, 64'h1);
    chk("t2_src", {60'h0, src_addr}, 64'h0);
    chk("t2_mod", {62'h0, mod}, 64'h0);
    @(negedge clock);
    chk("t2_valid_1cyc", valid, 0);
    idle(3);
    chk("t2_counts", {n_valid - b_valid, n_crc - b_crc}, {32'd1, 32'd0});

    // 16-bit frame to move src/mod away from their reset values.
    send_frame(4'h1, 4'h5, 2'd1, 64'hA5C3, crc_of(4'h1, 4'h5, 2'd1, 64'hA5C3), 1'b1, -1);
    chk("t2b_valid", s_valid, 1);
    chk("t2b_data", data, 64'hA5C3);
    chk("t2b_src", {60'h0, src_addr}, 64'h5);
    chk("t2b_mod", {62'h0, mod}, 64'h1);
    idle(3);

    // Same 8-bit frame with a corrupted CRC.
    mark();
    send_frame(4'h1, 4'h0, 2'd0, 64'h01, 4'hA, 1'b1, -1);
    chk("t3_crc_err", s_crc_err, 1);
    chk("t3_valid", s_valid, 0);
    chk("t3_data_hold", data, 64'hA5C3);
    chk("t3_src_hold", {60'h0, src_addr}, 64'h5);
    idle(3);
    chk("t3_counts", {n_valid - b_valid, n_crc - b_crc}, {32'd0, 32'd1});

    // Frame for another node, then a back-to-back 64-bit frame for us.
    addr = 4'h2;
    mark();
    send_frame(4'h1, 4'h0, 2'd0, 64'h01, 4'hB, 1'b1, -1);
    chk("t4_nomatch", {s_valid, s_crc_err, s_frame_err}, 0);
    send_frame(4'h2, 4'h0, 2'd3, 64'hDEADBEEF_01234567,
               crc_of(4'h2, 4'h0, 2'd3, 64'hDEADBEEF_01234567), 1'b1, -1);
    chk("t4_valid", s_valid, 1);
    chk("t4_data", data, 64'hDEADBEEF_01234567);
    chk("t4_mod", {62'h0, mod}, 64'h3);
    chk("t4_src", {60'h0, src_addr}, 64'h0);
    idle(3);
    chk("t4_counts", {n_valid - b_valid, n_crc - b_crc}, {32'd1, 32'd0});

    // Stop bit low, bus held low: no frame may start until the bus is high again.
    addr = 4'h0;
    mark();
    send_frame(4'h0, 4'h3, 2'd0, 64'h77, crc_of(4'h0, 4'h3, 2'd0, 64'h77), 1'b0, -1);
    chk("t5_frame_err", s_frame_err, 1);
    chk("t5_valid", s_valid, 0);
    idle(4);
    bus = 1'b1;
    idle(100);
    chk("t5_counts", {n_valid - b_valid, n_crc - b_crc, n_ferr - b_ferr}, {32'd0, 32'd0, 32'd1});
    send_frame(4'h0, 4'h6, 2'd0, 64'h3C, crc_of(4'h0, 4'h6, 2'd0, 64'h3C), 1'b1, -1);
    chk("t5_recover", s_valid, 1);
    chk("t5_recover_data", data, 64'h3C);
    idle(3);

    // Reset pulsed during payload bit 3 of an otherwise good frame.
    addr = 4'h1;
    send_frame(4'h1, 4'h0, 2'd0, 64'h01, 4'hB, 1'b1, 3);
    mark();
    idle(120);
    chk("t6_pulses", n_valid + n_crc + n_ferr - b_valid - b_crc - b_ferr, 0);
    chk("t6_data", data, 64'h0);
    chk("t6_src", {60'h0, src_addr}, 64'h0);
    send_frame(4'h1, 4'h9, 2'd2, 64'h12345678, crc_of(4'h1, 4'h9, 2'd2, 64'h12345678), 1'b1, -1);
    chk("t6_next_valid", s_valid, 1);
    chk("t6_next_data", data, 64'h12345678);
    chk("t6_next_src", {60'h0, src_addr}, 64'h9);
    chk("t6_next_mod", {62'h0, mod}, 64'h2);
    idle(3);

    // Broadcast destination.
    send_frame(4'hF, 4'h2, 2'd0, 64'hC3, crc_of(4'hF, 4'h2, 2'd0, 64'hC3), 1'b1, -1);
`ifdef BUS_RX_BROADCAST_EN
    chk("t7_bcast_valid", s_valid, 1);
    chk("t7_bcast_data", data, 64'hC3);
`else
    chk("t7_bcast_valid", s_valid, 0);
    chk("t7_bcast_data", data, 64'h12345678);
`endif
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
